// File: rtl/char_pkg.sv
// ASCII constants and whitespace classification shared by the normalizer.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package char_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_TAB      = 8'h09;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_NUL      = 8'h00;
  localparam logic [7:0] CH_LA       = 8'h61;
  localparam logic [7:0] CH_LZ       = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Space, tab, line feed and carriage return all count as word separators.
  function automatic logic is_ws(input logic [7:0] b);
    return (b == CH_SPACE) || (b == CH_TAB) || (b == CH_LF) || (b == CH_CR);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered head, so head_dat holds when empty.
// Latency: a push at edge N is visible at head_dat and !empty after edge N.
// Backpressure: caller must not push when full or pop when empty; clr wins over both.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;

  // Next state: write slot, advance pointers, track occupancy, preload the new head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // mem_d already carries this cycle's write, which covers the
      // push-into-empty and push+pop-at-one cases without a bypass mux.
      if (cnt_d != '0) begin
        head_d = mem_d[rd_ptr_d];
      end
    end
  end

  // State registers; storage is cleared too so nothing stale survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign full     = (cnt_q == (PW + 1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = head_q;

endmodule

// File: rtl/char_normalizer.sv
// Cleans a raw ASCII stream: whitespace -> one 0x20, NUL and leading blanks dropped, optional upcase.
// Latency: one cycle from input handshake to out_valid; no combinational in->out path.
// Backpressure: in_ready drops when the FIFO is full; a pop in that cycle does not re-raise it.
module char_normalizer
  import char_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit FOLD_CASE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [15:0] char_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_acc;
  logic          out_acc;
  logic          wr_vld;
  logic [7:0]    wr_dat;
  logic          prev_ws_q, prev_ws_d;
  logic [15:0]   char_cnt_q, char_cnt_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  // A flush cycle swallows both handshakes.
  assign in_acc    = in_valid && in_ready && !flush;
  assign out_acc   = out_valid && out_ready && !flush;

  // Classify the accepted byte and decide what, if anything, enters the FIFO.
  always_comb begin
    wr_vld    = 1'b0;
    wr_dat    = in_data;
    prev_ws_d = prev_ws_q;
    if (flush) begin
      prev_ws_d = 1'b1;
    end else if (in_acc && (in_data != CH_NUL)) begin
      if (is_ws(in_data)) begin
        // Only the first blank of a run survives, and never at stream start.
        wr_vld    = !prev_ws_q;
        wr_dat    = CH_SPACE;
        prev_ws_d = 1'b1;
      end else begin
        wr_vld    = 1'b1;
        prev_ws_d = 1'b0;
        if (FOLD_CASE && (in_data >= CH_LA) && (in_data <= CH_LZ)) begin
          wr_dat = in_data - CASE_OFFSET;
        end
      end
    end
  end

  // Delivered-character counter; sticks at all-ones and survives flush.
  always_comb begin
    char_cnt_d = char_cnt_q;
    if (out_acc && (char_cnt_q != 16'hFFFF)) begin
      char_cnt_d = char_cnt_q + 16'd1;
    end
  end

  // Whitespace-run flag and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ws_q  <= 1'b1;
      char_cnt_q <= 16'h0000;
    end else begin
      prev_ws_q  <= prev_ws_d;
      char_cnt_q <= char_cnt_d;
    end
  end

  assign char_cnt = char_cnt_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr      (flush),
    .push     (wr_vld),
    .push_dat (wr_dat),
    .pop      (out_acc),
    .head_dat (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  // Occupancy and the full flag must never disagree.
  a_full_cnt: assert property (@(posedge clk) disable iff (!reset_n)
                               fifo_full == (fifo_cnt == CW'(DEPTH)));

endmodule

// File: tb/tb_char_normalizer.sv
// Bench for char_normalizer: one folding and one non-folding instance share the stimulus.
// A queue model predicts every cycle; literal strings pin the model on each scenario.
// Inputs change 2 time units after posedge; outputs are sampled 1 unit after posedge.
module tb_char_normalizer;

  localparam int DEPTH = 4;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_data   = 8'h00;
  logic        out_ready = 1'b1;

  logic [1:0]  in_rdy;
  logic [1:0]  out_vld;
  logic [7:0]  out_dat [2];
  logic [15:0] ccnt    [2];

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model state per instance (0 = FOLD_CASE=1, 1 = FOLD_CASE=0).
  byte unsigned mq   [2][$];
  bit           mprev[2] = '{1'b1, 1'b1};
  int unsigned  mcnt [2] = '{0, 0};
  // Characters the DUTs actually delivered.
  byte unsigned cap  [2][$];

  always #5 clk = ~clk;

  char_normalizer #(.DEPTH(DEPTH), .FOLD_CASE(1'b1)) u_fold (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .out_valid(out_vld[0]), .out_ready(out_ready), .out_data(out_dat[0]),
    .char_cnt(ccnt[0])
  );

  char_normalizer #(.DEPTH(DEPTH), .FOLD_CASE(1'b0)) u_raw (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .out_valid(out_vld[1]), .out_ready(out_ready), .out_data(out_dat[1]),
    .char_cnt(ccnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input int k, input string name, input string exp);
    string got = "";
    for (int i = 0; i < cap[k].size(); i++) got = $sformatf("%s%c", got, cap[k][i]);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" (%0d chars), expected \"%s\" (%0d chars)",
               name, got, got.len(), exp, exp.len());
    end
    cap[k].delete();
  endtask

  // Model: the FIFO is a queue; classification follows the cleaning rules directly.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete(); mprev[k] = 1'b1; mcnt[k] = 0;
      end
    end else if (flush) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete(); mprev[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int sz = mq[k].size();
        if (out_ready && sz > 0) begin
          void'(mq[k].pop_front());
          if (mcnt[k] != 32'hFFFF) mcnt[k]++;
        end
        if (in_valid && sz != DEPTH && in_data != 8'h00) begin
          if (in_data inside {8'h20, 8'h09, 8'h0A, 8'h0D}) begin
            if (!mprev[k]) mq[k].push_back(8'h20);
            mprev[k] = 1'b1;
          end else begin
            mq[k].push_back((k == 0 && in_data >= 8'h61 && in_data <= 8'h7A)
                            ? in_data - 8'h20 : in_data);
            mprev[k] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_in_ready[%0d]", k), in_rdy[k], mq[k].size() != DEPTH);
        chk($sformatf("cyc_out_valid[%0d]", k), out_vld[k], mq[k].size() != 0);
        if (mq[k].size() != 0) chk($sformatf("cyc_out_data[%0d]", k), out_dat[k], mq[k][0]);
        chk($sformatf("cyc_char_cnt[%0d]", k), ccnt[k], mcnt[k]);
      end
    end
  end

  // Record delivered characters mid-cycle.
  always @(negedge clk) begin
    if (reset_n && !flush && out_ready) begin
      for (int k = 0; k < 2; k++) begin
        if (out_vld[k]) cap[k].push_back(out_dat[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && !done; t++) begin
      done = in_rdy[0];
      cyc();
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL send_timeout: byte %0h not accepted, required accept within 20 cycles", b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Offer s[idx..] for one cycle; advance idx if accepted.
  task automatic offer(input string s, inout int idx);
    bit acc;
    in_valid = (idx < s.len());
    in_data  = (idx < s.len()) ? s[idx] : 8'h00;
    acc      = in_valid && in_rdy[0];
    cyc();
    if (acc) idx++;
    in_valid = 1'b0;
  endtask

  initial begin
    int idx;
    #1;
    reset_n = 1'b0;
    chk_on  = 1'b1;
    idle(2);
    reset_n = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", out_vld[k], 0);
      chk("rst_out_data",  out_dat[k], 8'h00);
      chk("rst_char_cnt",  ccnt[k],    0);
      chk("rst_in_ready",  in_rdy[k],  1);
    end

    // Leading blanks dropped, tab becomes one space, trailing space kept.
    send_str("  begin\tEnd ");
    idle(3);
    chk_str(0, "t1_fold", "BEGIN END ");
    chk_str(1, "t1_raw",  "begin End ");
    chk("t1_char_cnt", ccnt[0], 10);

    // CR+LF collapse to one space, NUL vanishes.
    send_str("a\r\n");
    send(8'h00);
    send("b");
    idle(3);
    chk_str(1, "t2_raw",  "a b");
    chk_str(0, "t2_fold", "A B");
    chk("t2_char_cnt", ccnt[1], 13);

    // Stall downstream: only DEPTH bytes enter, head stays on first byte.
    out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 8; t++) offer("XYZWVU", idx);
    chk("t3_accepts",   idx,        4);
    chk("t3_in_ready",  in_rdy[0],  0);
    chk("t3_out_valid", out_vld[0], 1);
    chk("t3_head",      out_dat[0], "X");
    out_ready = 1'b1;
    for (int t = 0; t < 20 && idx < 6; t++) offer("XYZWVU", idx);
    chk("t3_all_accepted", idx, 6);
    idle(6);
    chk_str(0, "t3_fold", "XYZWVU");
    chk_str(1, "t3_raw",  "XYZWVU");

    // Build count 2, then 10 push+pop cycles across the pointer wrap.
    out_ready = 1'b0;
    send_str("PQ");
    chk("t4_head_pre", out_dat[0], "P");
    out_ready = 1'b1;
    send_str("ABCDEFGHIJ");
    out_ready = 1'b0;
    chk("t4_head_post", out_dat[0], "I");
    chk("t4_in_ready",  in_rdy[0],  1);
    out_ready = 1'b1;
    idle(4);
    chk_str(0, "t4_fold", "PQABCDEFGHIJ");
    chk_str(1, "t4_raw",  "PQABCDEFGHIJ");

    // Flush mid-stream with a competing push and pop.
    out_ready = 1'b0;
    send_str("BEG");
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = "I";
    out_ready = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_out_valid", out_vld[0], 0);
    chk("t5_char_cnt",  ccnt[0],    31);
    cyc();
    chk("t5_no_I", out_vld[1], 0);
    send_str(" x");
    idle(3);
    chk_str(0, "t5_fold", "X");
    chk_str(1, "t5_raw",  "x");
    chk("t5_char_cnt_after", ccnt[0], 32);

    // Asynchronous reset between edges with entries queued.
    out_ready = 1'b0;
    send_str("QRS");
    #1;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_out_valid", out_vld[k], 0);
      chk("t6_char_cnt",  ccnt[k],    0);
      chk("t6_out_data",  out_dat[k], 8'h00);
    end
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("t6_in_ready",   in_rdy[0],  1);
    chk("t6_out_valid2", out_vld[0], 0);
    out_ready = 1'b1;
    send_str(" Z");
    idle(3);
    chk_str(0, "t6_fold", "Z");
    chk_str(1, "t6_raw",  "Z");
    chk("t6_char_cnt_after", ccnt[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_normalizer.md
Name: char_normalizer

Overview:
- Upstream stage of the BEGIN/END block checker. Accepts a raw ASCII byte stream over a valid/ready handshake and emits a cleaned stream of one character per handshake.
- Cleaning steps:
  - map whitespace to 0x20;
  - collapse runs of whitespace into one space;
  - drop NUL and leading whitespace;
  - optionally fold lower case to upper case.
- Buffers results in a small FIFO. The checker's per-cycle character input is driven from out_data and gated by out_valid.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- FOLD_CASE, 1, 1 = map 'a'..'z' to 'A'..'Z'; 0 = pass letters unchanged.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO and whitespace state.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  8  raw ASCII byte.
- out_valid  output  1  FIFO head holds a character.
- out_ready  input  1  downstream consumes the head this cycle.
- out_data  output  8  normalized character at FIFO head.
- char_cnt  output  16  characters delivered downstream, saturating.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, out_valid=0, out_data=8'h00, char_cnt=0, prev_ws=1. in_ready=1 once reset is released.
- Input handshake: accept when in_valid && in_ready.
  - in_ready = (count != DEPTH), independent of in_data.
  - When full, a same-cycle pop does not raise in_ready (no pass-through).
- Classification of an accepted byte b:
  - WS = {0x20, 0x09, 0x0A, 0x0D}.
  - b == 0x00: consume, write nothing, prev_ws unchanged.
  - b in WS and prev_ws == 1: consume, write nothing.
  - b in WS and prev_ws == 0: write 0x20, set prev_ws = 1.
  - Otherwise: write f(b), set prev_ws = 0. f(b) = b - 0x20 if FOLD_CASE && 'a' <= b <= 'z', else b.
- Latency: a byte written at edge N is visible with out_valid=1 in the cycle after edge N (1 cycle). No combinational path from in_* to out_*.
- Output handshake: pop when out_valid && out_ready.
  - out_data is the head entry; it holds stable while out_valid && !out_ready.
  - When empty, out_data holds its last value; it is not meaningful.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count in 1..DEPTH-1 (when full, in_ready=0 so no push occurs).
- Pointers: log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH. A separate count of log2(DEPTH)+1 bits drives full/empty.
- char_cnt: increments on each output handshake and saturates at 16'hFFFF.
- flush (synchronous, highest priority after reset):
  - next state is count=0, prev_ws=1;
  - any input or output handshake in the same cycle is ignored;
  - char_cnt is NOT cleared.
- Reset asserted mid-stream: all state is cleared immediately; no partial character survives.
- Trailing space: never suppressed. A final word followed by whitespace yields exactly one trailing 0x20. The checker relies on this to close its last word.

Decomposition:
- Package char_pkg holds the ASCII constants: CH_SPACE=8'h20, CH_TAB=8'h09, CH_LF=8'h0A, CH_CR=8'h0D, CH_NUL=8'h00, CH_LA=8'h61, CH_LZ=8'h7A, CASE_OFFSET=8'h20.
- Package char_pkg also holds the function is_ws(byte).
- One natural sub-module: sync_fifo (parameter DEPTH, width 8, push/pop/full/empty/count, active-low async reset). char_normalizer instantiates it and adds the classification logic, prev_ws flag and char_cnt.

Test Plan:
- Feed "  begin\tEnd " with out_ready=1 -> out_data sequence is "BEGIN END " (10 chars); char_cnt=10; leading spaces and the tab run are collapsed.
- Feed "a\r\n\x00b" with FOLD_CASE=0 -> "a b" (0x61, 0x20, 0x62); the NUL produces no output.
- Hold out_ready=0 and stream 6 non-WS bytes with DEPTH=4 -> in_ready drops after the 4th accept; out_data stays 'X' (first byte) and stable. Then raise out_ready -> remaining bytes drain in order with no loss or duplication.
- With FIFO at count 2, issue push and pop in the same cycle -> count stays 2 and order is preserved. Repeat across the pointer wrap (10 consecutive push+pop cycles) -> the output sequence equals the input sequence.
- Mid-stream (after "BEG"), assert flush for 1 cycle alongside in_valid=1, in_data='I' -> next cycle out_valid=0 and 'I' is not stored; a subsequent " x" yields only "X" (leading space dropped); char_cnt is unchanged by the flush.
- Pull reset_n low asynchronously between clock edges with 3 entries queued -> out_valid=0 and char_cnt=0 immediately, before the next edge. After release, in_ready=1 and prev_ws=1.
